cache_plru: RTL and testbench



---
 rtl/cache_plru_pkg.sv | 23 ++
 rtl/cache_plru_tree.sv | 51 +++++
 rtl/cache_plru.sv | 99 +++++++++
 tb/tb_cache_plru.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_plru_pkg.sv
// Shared cache package: default geometry, index types and PLRU sizing helpers.
package cache_plru_pkg;

    localparam int CACHE_NUM_WAYS  = 4;
    localparam int CACHE_NUM_SETS  = 32;
    localparam int CACHE_WAY_IDX_W = (CACHE_NUM_WAYS > 1) ? $clog2(CACHE_NUM_WAYS) : 1;
    localparam int CACHE_SET_IDX_W = $clog2(CACHE_NUM_SETS);
    localparam int PLRU_NODES      = CACHE_NUM_WAYS - 1;

    typedef logic [CACHE_WAY_IDX_W-1:0] way_idx_t;
    typedef logic [CACHE_SET_IDX_W-1:0] set_idx_t;

    // A single-way cache still needs a 1-bit way index on its ports.
    function automatic int way_idx_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Tree node count, floored at 1 so storage vectors never collapse to zero width.
    function automatic int plru_node_width(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// Combinational binary-tree PLRU: victim walk and mark-used update for one set.
// Node 0 is the root, node i has children 2i+1 / 2i+2; flag 0 points to the lower half.
module plru_tree #(
    parameter int NUM_WAYS      = 4,
    parameter int WAY_IDX_WIDTH = 2,
    parameter int NODE_W        = 3
) (
    input  logic [NODE_W-1:0]        flags,
    input  logic [WAY_IDX_WIDTH-1:0] used_way,
    output logic [WAY_IDX_WIDTH-1:0] victim_way,
    output logic [NODE_W-1:0]        updated_flags
);

    localparam int LEVELS = $clog2(NUM_WAYS);

    // Follow the flags from the root down to a leaf; leaf offset is the victim way.
    always_comb begin
        int   node;
        logic flag_bit;
        node     = 0;
        flag_bit = 1'b0;
        for (int l = 0; l < LEVELS; l++) begin
            flag_bit = 1'b0;
            for (int k = 0; k < NODE_W; k++) begin
                if (k == node) flag_bit = flags[k];
            end
            node = 2 * node + (flag_bit ? 2 : 1);
        end
        victim_way = WAY_IDX_WIDTH'(node - (NUM_WAYS - 1));
    end

    // Point every node on the path to used_way away from it; other nodes keep their value.
    always_comb begin
        int                       node;
        logic                     dir;
        logic [WAY_IDX_WIDTH-1:0] shifted;
        updated_flags = flags;
        node          = 0;
        dir           = 1'b0;
        shifted       = '0;
        for (int l = 0; l < LEVELS; l++) begin
            shifted = used_way >> (LEVELS - 1 - l);
            dir     = shifted[0];
            for (int k = 0; k < NODE_W; k++) begin
                if (k == node) updated_flags[k] = ~dir;
            end
            node = 2 * node + (dir ? 2 : 1);
        end
    end

endmodule

// File: rtl/cache_plru.sv
// Per-set pseudo-LRU victim selector: fill request in cycle N returns its victim in N+1.
module cache_plru
    import cache_plru_pkg::*;
#(
    parameter int NUM_WAYS      = CACHE_NUM_WAYS,
    parameter int NUM_SETS      = CACHE_NUM_SETS,
    parameter int SET_IDX_WIDTH = $clog2(NUM_SETS),
    parameter int WAY_IDX_WIDTH = way_idx_width(NUM_WAYS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fill_en,
    input  logic [SET_IDX_WIDTH-1:0] fill_set,
    input  logic                     hit_en,
    input  logic [SET_IDX_WIDTH-1:0] hit_set,
    input  logic [WAY_IDX_WIDTH-1:0] hit_way,
    output logic                     fill_way_valid,
    output logic [WAY_IDX_WIDTH-1:0] fill_way
);

    localparam int NODE_W = plru_node_width(NUM_WAYS);

    logic                     pend_valid;
    logic [SET_IDX_WIDTH-1:0] pend_set;

    // Stage 1: capture the fill request; its victim is presented the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_set   <= '0;
        end else begin
            pend_valid <= fill_en;
            if (fill_en) pend_set <= fill_set;
        end
    end

    assign fill_way_valid = pend_valid;

    generate
        if (NUM_WAYS == 1) begin : g_single
            logic unused_single;
            assign unused_single = ^{hit_en, hit_set, hit_way, pend_set};
            assign fill_way      = '0;
        end else begin : g_tree
            logic [NODE_W-1:0]        flags [NUM_SETS];
            logic [NODE_W-1:0]        fill_next;
            logic [NODE_W-1:0]        hit_next;
            logic [NODE_W-1:0]        unused_victim_flags;
            logic [WAY_IDX_WIDTH-1:0] victim;
            logic [WAY_IDX_WIDTH-1:0] held_way;
            logic [WAY_IDX_WIDTH-1:0] unused_fill_victim;
            logic [WAY_IDX_WIDTH-1:0] unused_hit_victim;
            logic                     hit_dropped;

            plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_IDX_WIDTH(WAY_IDX_WIDTH), .NODE_W(NODE_W)) u_victim (
                .flags         (flags[pend_set]),
                .used_way      ('0),
                .victim_way    (victim),
                .updated_flags (unused_victim_flags)
            );

            plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_IDX_WIDTH(WAY_IDX_WIDTH), .NODE_W(NODE_W)) u_fill_mark (
                .flags         (flags[pend_set]),
                .used_way      (victim),
                .victim_way    (unused_fill_victim),
                .updated_flags (fill_next)
            );

            plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_IDX_WIDTH(WAY_IDX_WIDTH), .NODE_W(NODE_W)) u_hit_mark (
                .flags         (flags[hit_set]),
                .used_way      (hit_way),
                .victim_way    (unused_hit_victim),
                .updated_flags (hit_next)
            );

            // A hit colliding with the stage-2 fill on the same set loses to the fill.
            assign hit_dropped = pend_valid && (hit_set == pend_set);

            // Flag storage: commit hit and fill recency updates at the end of the cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < NUM_SETS; s++) flags[s] <= '0;
                end else begin
                    if (hit_en && !hit_dropped) flags[hit_set] <= hit_next;
                    if (pend_valid)             flags[pend_set] <= fill_next;
                end
            end

            // Remember the last presented victim so fill_way is stable while idle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)           held_way <= '0;
                else if (pend_valid) held_way <= victim;
            end

            assign fill_way = pend_valid ? victim : held_way;
        end
    endgenerate

endmodule

// File: tb/tb_cache_plru.sv
// Bench for cache_plru: 4-way default plus 1/2/8-way instances checked by a scoreboard.
module tb_cache_plru;

    logic       clk = 1'b0;
    logic       reset;
    logic       fill_en, hit_en;
    logic [4:0] fill_set, hit_set;
    logic [1:0] hw4;
    logic [0:0] hw1, hw2;
    logic [2:0] hw8;
    logic       fv4, fv1, fv2, fv8;
    logic [1:0] fw4;
    logic [0:0] fw1, fw2;
    logic [2:0] fw8;

    int n_cmp = 0;
    int n_mis = 0;

    logic [6:0] mflags [4][32];
    bit         m_pend;
    int         m_pset;
    int         m_pv   [4];
    int         m_last [4];
    int         exp_q  [$];

    always #5 clk = ~clk;

    cache_plru #(.NUM_WAYS(4)) u_w4 (.clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set),
        .hit_en(hit_en), .hit_set(hit_set), .hit_way(hw4), .fill_way_valid(fv4), .fill_way(fw4));
    cache_plru #(.NUM_WAYS(1)) u_w1 (.clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set),
        .hit_en(hit_en), .hit_set(hit_set), .hit_way(hw1), .fill_way_valid(fv1), .fill_way(fw1));
    cache_plru #(.NUM_WAYS(2)) u_w2 (.clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set),
        .hit_en(hit_en), .hit_set(hit_set), .hit_way(hw2), .fill_way_valid(fv2), .fill_way(fw2));
    cache_plru #(.NUM_WAYS(8)) u_w8 (.clk(clk), .reset(reset), .fill_en(fill_en), .fill_set(fill_set),
        .hit_en(hit_en), .hit_set(hit_set), .hit_way(hw8), .fill_way_valid(fv8), .fill_way(fw8));

    function automatic int cfg_ways(input int c);
        case (c)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] obs_way(input int c);
        case (c)
            0:       return {30'b0, fw4};
            1:       return {31'b0, fw1};
            2:       return {31'b0, fw2};
            default: return {29'b0, fw8};
        endcase
    endfunction

    function automatic logic [31:0] obs_valid(input int c);
        case (c)
            0:       return {31'b0, fv4};
            1:       return {31'b0, fv1};
            2:       return {31'b0, fv2};
            default: return {31'b0, fv8};
        endcase
    endfunction

    // Reference PLRU: walk from the root, flag 0 = lower half, 1 = upper half.
    function automatic int m_victim(input logic [6:0] f, input int ways);
        int lv;
        int node;
        lv   = (ways > 1) ? $clog2(ways) : 0;
        node = 0;
        for (int l = 0; l < lv; l++) node = 2 * node + 1 + (f[node] ? 1 : 0);
        return node - (ways - 1);
    endfunction

    function automatic logic [6:0] m_mark(input logic [6:0] f, input int w, input int ways);
        int lv;
        int node;
        int d;
        lv   = (ways > 1) ? $clog2(ways) : 0;
        node = 0;
        for (int l = 0; l < lv; l++) begin
            d       = (w >> (lv - 1 - l)) & 1;
            f[node] = (d == 0);
            node    = 2 * node + 1 + d;
        end
        return f;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 32; s++) mflags[c][s] = '0;
            m_pv[c]   = 0;
            m_last[c] = 0;
        end
        m_pend = 1'b0;
        m_pset = 0;
        exp_q.delete();
    endtask

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s ways=%0d: observed %0d expected %0d", tag, cfg_ways(c), obs, expv);
        end
    endtask

    // One clock of stimulus: drive at negedge, advance the model, sample #1 after posedge.
    task automatic step(input bit fe, input int fs, input bit he, input int hs, input int hw);
        int w;
        int v;
        int e;
        @(negedge clk);
        fill_en  = fe;
        fill_set = 5'(fs);
        hit_en   = he;
        hit_set  = 5'(hs);
        hw4      = 2'(hw);
        hw1      = 1'b0;
        hw2      = 1'(hw);
        hw8      = 3'(hw);
        for (int c = 0; c < 4; c++) begin
            w = hw & (cfg_ways(c) - 1);
            if (he && !(m_pend && hs == m_pset))
                mflags[c][hs] = m_mark(mflags[c][hs], w, cfg_ways(c));
            if (m_pend)
                mflags[c][m_pset] = m_mark(mflags[c][m_pset], m_pv[c], cfg_ways(c));
        end
        if (fe) begin
            for (int c = 0; c < 4; c++) begin
                v       = m_victim(mflags[c][fs], cfg_ways(c));
                m_pv[c] = v;
                exp_q.push_back(v);
            end
        end
        m_pend = fe;
        m_pset = fs;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            check("valid", c, obs_valid(c), {31'b0, m_pend});
            if (m_pend) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check("victim", c, obs_way(c), e);
                if (e >= 0) m_last[c] = e;
            end else begin
                check("hold", c, obs_way(c), m_last[c]);
            end
        end
    endtask

    initial begin
        int seq3 [5];
        int fs;
        seq3 = '{0, 2, 1, 3, 0};

        reset = 1'b1; fill_en = 1'b0; hit_en = 1'b0;
        fill_set = '0; hit_set = '0; hw4 = '0; hw1 = '0; hw2 = '0; hw8 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            check("reset_valid", c, obs_valid(c), 0);
            check("reset_way", c, obs_way(c), 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back fills to set 3.
        for (int i = 0; i < 5; i++) begin
            step(1, 3, 0, 0, 0);
            check("seq_set3", 0, {30'b0, fw4}, seq3[i]);
        end
        step(0, 0, 0, 0, 0);

        // Hits steer the next victim.
        step(0, 0, 1, 5, 0);
        step(1, 5, 0, 0, 0);
        check("hit_w0_fill", 0, {30'b0, fw4}, 2);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 2);
        step(1, 5, 0, 0, 0);
        check("hit_w2_fill", 0, {30'b0, fw4}, 1);
        step(0, 0, 0, 0, 0);

        // Same-set collision: hit on set 7 during its stage-2 fill is dropped.
        step(1, 7, 0, 0, 0);
        step(0, 0, 1, 7, 1);
        step(1, 7, 0, 0, 0);
        check("collide_fill1", 0, {30'b0, fw4}, 2);
        step(1, 7, 0, 0, 0);
        check("collide_fill2", 0, {30'b0, fw4}, 1);
        step(0, 0, 0, 0, 0);

        // Different-set: hit on set 8 during a set-7 stage-2 fill is kept.
        step(1, 7, 0, 0, 0);
        step(0, 0, 1, 8, 1);
        step(1, 8, 0, 0, 0);
        check("split_set8", 0, {30'b0, fw4}, 2);
        step(0, 0, 0, 0, 0);

        // Reset asserted mid-cycle while a fill request is being presented.
        @(negedge clk);
        fill_en  = 1'b1;
        fill_set = 5'd3;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            check("midrst_valid", c, obs_valid(c), 0);
            check("midrst_way", c, obs_way(c), 0);
        end
        @(negedge clk);
        fill_en = 1'b0;
        reset   = 1'b0;
        step(1, 3, 0, 0, 0);
        check("post_rst_s3", 0, {30'b0, fw4}, 0);
        step(1, 5, 0, 0, 0);
        check("post_rst_s5", 0, {30'b0, fw4}, 0);
        step(1, 7, 0, 0, 0);
        check("post_rst_s7", 0, {30'b0, fw4}, 0);
        step(1, 8, 0, 0, 0);
        check("post_rst_s8", 0, {30'b0, fw4}, 0);
        step(0, 0, 0, 0, 0);

        // Random fill/hit traffic, concentrated on a few sets to force collisions.
        for (int i = 0; i < 10000; i++) begin
            fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
            step(($urandom_range(0, 9) < 6), fs,
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)));
        end
        step(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
